// File: rtl/context_assembler_if.sv
// context_assembler_if: control, document-storage read port and output stream of the context assembler
interface context_assembler_if #(
   parameter int MAX_SEQUENCE_LEN = 512,
   parameter int TOP_K = 5,
   parameter int MAX_CONTEXT_LEN = 2048
);
   logic start;
   logic busy;
   logic done;
   logic [TOP_K-1:0] doc_included;
   logic [TOP_K-1:0][31:0] doc_lengths;
   logic rd_en;
   logic [$clog2(TOP_K)-1:0] rd_doc;
   logic [$clog2(MAX_SEQUENCE_LEN)-1:0] rd_addr;
   logic [7:0] rd_data;
   logic out_valid;
   logic out_ready;
   logic [7:0] out_data;
   logic out_last;
   logic [$clog2(MAX_CONTEXT_LEN+1)-1:0] out_count;
   logic truncated;
   logic empty_ctx;
   modport master (
      output start, doc_included, doc_lengths, rd_data, out_ready,
      input busy, done, rd_en, rd_doc, rd_addr, out_valid, out_data, out_last, out_count, truncated, empty_ctx
   );
   modport slave (
      input start, doc_included, doc_lengths, rd_data, out_ready,
      output busy, done, rd_en, rd_doc, rd_addr, out_valid, out_data, out_last, out_count, truncated, empty_ctx
   );
endinterface

// File: rtl/context_assembler.sv
// context_assembler: streams included documents in index order, separator-delimited and truncated at the context budget
module context_assembler #(
   parameter int MAX_SEQUENCE_LEN = 512,
   parameter int TOP_K = 5,
   parameter int MAX_CONTEXT_LEN = 2048,
   parameter logic [7:0] SEP_BYTE = 8'h0A
) (
   input logic clk,
   input logic rst_n,
   context_assembler_if.slave bus
);
   localparam int DW = $clog2(TOP_K);
   localparam int AW = $clog2(MAX_SEQUENCE_LEN);
   localparam int LW = $clog2(MAX_SEQUENCE_LEN + 1);
   localparam int CW = $clog2(MAX_CONTEXT_LEN + 1);
   typedef enum logic [2:0] {IDLE, SCAN, SEP, READ, DRAIN, DONE} state_t;
   state_t st;
   logic [TOP_K-1:0] v;
   logic [LW-1:0] len [TOP_K];
   logic [DW-1:0] idx;
   logic [AW-1:0] addr;
   logic [CW-1:0] sent;
   logic [8:0] fifo [2];
   logic [1:0] cnt;
   logic wp, rp, rd_vld, rd_lst;
   logic pop, credit, eod, more, fin_budget, sep_kill, lastb, issue, sep_push;
   // credit counts this cycle's pop so a 2-entry FIFO still sustains 1 byte/cycle
   always_comb begin
      pop = bus.out_valid && bus.out_ready;
      credit = 32'(cnt) + 32'(rd_vld) < 32'd2 + 32'(pop);
      eod = 32'(addr) + 1 == 32'(len[idx]);
      more = |((v >> idx) >> 1);
      fin_budget = 32'(sent) + 1 == MAX_CONTEXT_LEN;
      sep_kill = eod && more && 32'(sent) + 2 == MAX_CONTEXT_LEN;
      lastb = fin_budget || (eod && !more) || sep_kill;
      issue = st == READ && credit;
      sep_push = st == SEP && credit;
   end
   assign bus.rd_en = issue;
   assign bus.rd_doc = idx;
   assign bus.rd_addr = addr;
   assign bus.out_valid = cnt != 2'd0;
   assign bus.out_data = fifo[rp][7:0];
   assign bus.out_last = bus.out_valid && fifo[rp][8];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo <= '{default: '0};
         cnt <= '0;
         wp <= 1'b0;
         rp <= 1'b0;
         rd_vld <= 1'b0;
         rd_lst <= 1'b0;
      end else begin
         if (rd_vld || sep_push) begin
            fifo[wp] <= rd_vld ? {rd_lst, bus.rd_data} : {1'b0, SEP_BYTE};
            wp <= ~wp;
         end
         if (pop) rp <= ~rp;
         cnt <= cnt + 2'(rd_vld || sep_push) - 2'(pop);
         rd_vld <= issue;
         rd_lst <= lastb;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st <= IDLE;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.truncated <= 1'b0;
         bus.empty_ctx <= 1'b0;
         bus.out_count <= '0;
         v <= '0;
         len <= '{default: '0};
         idx <= '0;
         addr <= '0;
         sent <= '0;
      end else begin
         if (pop && 32'(bus.out_count) < MAX_CONTEXT_LEN) bus.out_count <= bus.out_count + 1'b1;
         case (st)
            IDLE: if (bus.start) begin
               st <= SCAN;
               bus.busy <= 1'b1;
               bus.out_count <= '0;
               bus.truncated <= 1'b0;
               bus.empty_ctx <= 1'b0;
               idx <= '0;
               addr <= '0;
               sent <= '0;
               for (int i = 0; i < TOP_K; i++) begin
                  len[i] <= bus.doc_lengths[i] > 32'(MAX_SEQUENCE_LEN) ? LW'(MAX_SEQUENCE_LEN) : bus.doc_lengths[i][LW-1:0];
                  v[i] <= bus.doc_included[i] && bus.doc_lengths[i] != 32'd0;
               end
            end
            SCAN: if (v[idx]) st <= sent == '0 ? READ : SEP;
               else if (32'(idx) >= TOP_K - 1) st <= DRAIN;
               else idx <= idx + 1'b1;
            SEP: if (sep_push) begin
               sent <= sent + 1'b1;
               st <= READ;
            end
            // a doc byte whose trailing separator would take the final slot becomes the last byte
            READ: if (issue) begin
               sent <= sent + 1'b1;
               addr <= eod ? '0 : addr + 1'b1;
               if (lastb) begin
                  st <= DRAIN;
                  bus.truncated <= !(eod && !more);
               end else if (eod) begin
                  st <= SCAN;
                  idx <= idx + 1'b1;
               end
            end
            DRAIN: if (cnt == 2'd0 && !rd_vld) begin
               st <= DONE;
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               bus.empty_ctx <= bus.out_count == '0;
            end
            DONE: begin
               st <= IDLE;
               bus.done <= 1'b0;
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_context_assembler.sv
// tb_context_assembler: table-driven scoreboard bench for context_assembler at budgets 2048 and 8
module tb_context_assembler;
   typedef struct packed {
      logic sel;
      logic rnd;
      logic [4:0] mask;
      logic [4:0][31:0] lens;
      logic [11:0] cnt;
      logic trunc;
      logic empty;
      logic cont;
   } vec_t;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b1, sel = 1'b0, rmode = 1'b0;
   logic [4:0] mask = '0;
   logic [4:0][31:0] lens = '0;
   int n_chk = 0, n_fail = 0;
   logic [8:0] q [$];
   logic hold = 1'b0;
   logic [8:0] held = '0;
   vec_t vt [12];
   context_assembler_if #(.MAX_SEQUENCE_LEN(512), .TOP_K(5), .MAX_CONTEXT_LEN(2048)) b0 ();
   context_assembler_if #(.MAX_SEQUENCE_LEN(512), .TOP_K(5), .MAX_CONTEXT_LEN(8)) b1 ();
   context_assembler #(.MAX_SEQUENCE_LEN(512), .TOP_K(5), .MAX_CONTEXT_LEN(2048), .SEP_BYTE(8'h0A)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
   context_assembler #(.MAX_SEQUENCE_LEN(512), .TOP_K(5), .MAX_CONTEXT_LEN(8), .SEP_BYTE(8'h0A)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
   assign b0.start = start && !sel;
   assign b1.start = start && sel;
   assign b0.doc_included = mask;
   assign b1.doc_included = mask;
   assign b0.doc_lengths = lens;
   assign b1.doc_lengths = lens;
   assign b0.out_ready = ready;
   assign b1.out_ready = ready;
   logic done_s, busy_s, valid_s, last_s, trunc_s, empty_s;
   logic [7:0] data_s;
   logic [11:0] cnt_s;
   assign done_s = sel ? b1.done : b0.done;
   assign busy_s = sel ? b1.busy : b0.busy;
   assign valid_s = sel ? b1.out_valid : b0.out_valid;
   assign last_s = sel ? b1.out_last : b0.out_last;
   assign trunc_s = sel ? b1.truncated : b0.truncated;
   assign empty_s = sel ? b1.empty_ctx : b0.empty_ctx;
   assign data_s = sel ? b1.out_data : b0.out_data;
   assign cnt_s = sel ? 12'(b1.out_count) : b0.out_count;
   always #5 clk = ~clk;
   function automatic logic [7:0] mem(input logic [2:0] d, input logic [8:0] a);
      return 8'(32'(d) * 16 + 32'(a));
   endfunction
   function automatic logic [4:0][31:0] L(input int a, input int b, input int c, input int d, input int e);
      return {32'(e), 32'(d), 32'(c), 32'(b), 32'(a)};
   endfunction
   function automatic vec_t V(input logic s, input logic r, input logic [4:0] m, input logic [4:0][31:0] l,
                              input int c, input logic t, input logic e, input logic k);
      return '{sel: s, rnd: r, mask: m, lens: l, cnt: 12'(c), trunc: t, empty: e, cont: k};
   endfunction
   always @(posedge clk) if (b0.rd_en) b0.rd_data <= mem(b0.rd_doc, b0.rd_addr);
   always @(posedge clk) if (b1.rd_en) b1.rd_data <= mem(b1.rd_doc, b1.rd_addr);
   always @(posedge clk) begin
      #1;
      ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
   end
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_s && ready) begin
            check("byte_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) check("stream_byte", 32'({last_s, data_s}), 32'(q.pop_front()));
         end
         if (hold && valid_s) check("stall_hold", 32'({last_s, data_s}), 32'(held));
         hold = valid_s && !ready;
         held = {last_s, data_s};
      end else hold = 1'b0;
   end
   task automatic build(input logic [4:0] m, input logic [4:0][31:0] l, input int maxc);
      logic [8:0] t [$];
      logic first;
      logic [31:0] eff;
      first = 1'b1;
      for (int d = 0; d < 5; d++) begin
         eff = l[d] > 32'd512 ? 32'd512 : l[d];
         if (m[d] && eff != 32'd0) begin
            if (!first) t.push_back({1'b1, 8'h0A});
            for (int o = 0; o < int'(eff); o++) t.push_back({1'b0, mem(3'(d), 9'(o))});
            first = 1'b0;
         end
      end
      while (t.size() > maxc) void'(t.pop_back());
      if (t.size() > 0 && t[t.size()-1][8]) void'(t.pop_back());
      for (int i = 0; i < t.size(); i++) q.push_back({1'(i == t.size() - 1), t[i][7:0]});
   endtask
   task automatic run(input vec_t v);
      int fv, ft, lt, ntx, dc;
      sel = v.sel;
      rmode = v.rnd;
      mask = v.mask;
      lens = v.lens;
      build(v.mask, v.lens, v.sel ? 8 : 2048);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      fv = -1; ft = -1; lt = -1; ntx = 0; dc = -1;
      for (int cyc = 0; cyc < 3000 && dc < 0; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (valid_s && fv < 0) fv = cyc;
         if (valid_s && ready) begin
            ntx++;
            if (ft < 0) ft = cyc;
            lt = cyc;
         end
         if (done_s) dc = cyc;
         if (cyc == 3) begin
            mask = ~v.mask;
            lens = '1;
            start = 1'b1;
         end
         if (cyc == 4) start = 1'b0;
      end
      check("done_seen", 32'(dc >= 0), 32'd1);
      check("busy_at_done", 32'(busy_s), 32'd0);
      @(negedge clk);
      check("done_pulse", 32'(done_s), 32'd0);
      check("out_count", 32'(cnt_s), 32'(v.cnt));
      check("transfers", 32'(ntx), 32'(v.cnt));
      check("truncated", 32'(trunc_s), 32'(v.trunc));
      check("empty_ctx", 32'(empty_s), 32'(v.empty));
      check("bytes_left", 32'(q.size()), 32'd0);
      if (v.empty) begin
         check("no_valid", 32'(fv < 0), 32'd1);
         check("empty_done_latency", 32'(dc <= 7), 32'd1);
      end else check("first_valid_latency", 32'(fv >= 0 && fv <= 8), 32'd1);
      if (v.cont) check("throughput", 32'(lt - ft + 1), 32'(ntx));
      q.delete();
      rmode = 1'b0;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      vt[0] = V(0, 0, 5'b10101, L(3, 9, 4, 9, 2), 11, 0, 0, 0);
      vt[1] = V(0, 1, 5'b10101, L(3, 9, 4, 9, 2), 11, 0, 0, 0);
      vt[2] = V(1, 0, 5'b00011, L(6, 6, 0, 0, 0), 8, 1, 0, 0);
      vt[3] = V(0, 0, 5'b00000, L(3, 3, 3, 3, 3), 0, 0, 1, 0);
      vt[4] = V(0, 0, 5'b00110, L(7, 0, 612, 0, 0), 512, 0, 0, 1);
      vt[5] = V(0, 0, 5'b11111, L(0, 0, 0, 0, 0), 0, 0, 1, 0);
      vt[6] = V(0, 0, 5'b10000, L(0, 0, 0, 0, 1), 1, 0, 0, 0);
      vt[7] = V(1, 0, 5'b00011, L(7, 3, 0, 0, 0), 7, 1, 0, 0);
      vt[8] = V(1, 0, 5'b00001, L(8, 0, 0, 0, 0), 8, 0, 0, 1);
      vt[9] = V(0, 0, 5'b00001, L(-1, 0, 0, 0, 0), 512, 0, 0, 1);
      vt[10] = V(1, 0, 5'b00101, L(3, 0, 4, 0, 0), 8, 0, 0, 0);
      vt[11] = V(1, 1, 5'b11111, L(3, 3, 3, 0, 0), 7, 1, 0, 0);
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(b0.busy), 32'd0);
      check("rst_done", 32'(b0.done), 32'd0);
      check("rst_rd_en", 32'(b0.rd_en), 32'd0);
      check("rst_rd_doc", 32'(b0.rd_doc), 32'd0);
      check("rst_rd_addr", 32'(b0.rd_addr), 32'd0);
      check("rst_out_valid", 32'(b0.out_valid), 32'd0);
      check("rst_out_data", 32'(b0.out_data), 32'd0);
      check("rst_out_last", 32'(b0.out_last), 32'd0);
      check("rst_out_count", 32'(b0.out_count), 32'd0);
      check("rst_truncated", 32'(b0.truncated), 32'd0);
      check("rst_empty_ctx", 32'(b0.empty_ctx), 32'd0);
      check("rst_b1_valid", 32'(b1.out_valid), 32'd0);
      @(posedge clk) #2 rst_n = 1'b1;
      sel = 1'b0;
      mask = 5'b10101;
      lens = L(3, 9, 4, 9, 2);
      build(mask, lens, 2048);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int i = 0; i < 100 && cnt_s != 12'd5; i++) @(negedge clk);
      check("pre_reset_count", 32'(cnt_s), 32'd5);
      @(posedge clk) #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy_s), 32'd0);
      check("midrst_valid", 32'(valid_s), 32'd0);
      check("midrst_count", 32'(cnt_s), 32'd0);
      check("midrst_rd_en", 32'(b0.rd_en), 32'd0);
      q.delete();
      @(posedge clk);
      @(posedge clk) #2 rst_n = 1'b1;
      run(V(0, 0, 5'b00001, L(2, 0, 0, 0, 0), 2, 0, 0, 1));
      for (int i = 0; i < 12; i++) run(vt[i]);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
